// File: rtl/text_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : text_pkg
//  Description : Shared definitions for the text console front end:
//                control-code values and the writer FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package text_pkg;

  // Control codes recognised in the character stream
  localparam logic [7:0] CTRL_BS = 8'h08;  // backspace
  localparam logic [7:0] CTRL_LF = 8'h0A;  // line feed
  localparam logic [7:0] CTRL_FF = 8'h0C;  // form feed (clear screen)
  localparam logic [7:0] CTRL_CR = 8'h0D;  // carriage return

  // Writer FSM states
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

endpackage : text_pkg
`default_nettype wire

// File: rtl/text_console_writer.sv
`default_nettype none
// ============================================================================
//  Module      : text_console_writer
//  Description : Converts a byte stream of character/control codes into
//                writes on the text overlay's character-table port. Keeps a
//                row-major cursor with wrap-around, handles CR/LF/BS/FF and
//                blanks the whole table after reset or on request.
//  Ports       : i_clk, i_rst_n         - clock, async active-low reset
//                i_dv, i_data, o_ready  - input code stream handshake
//                i_clear                - single-cycle clear-screen request
//                o_wr_en, o_wr_character,
//                o_wr_x_pos, o_wr_y_pos - registered table write port
//                o_cursor_x, o_cursor_y - current cursor position
//                o_busy                 - clear sweep in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module text_console_writer
  import text_pkg::*;
#(
  parameter int COLUMNS       = 12,
  parameter int ROWS          = 2,
  parameter int FONT_NUM_CHAR = 256,
  parameter int BLANK_CHAR    = 8'h20,
  localparam int CW = $clog2(FONT_NUM_CHAR),
  localparam int XW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1,
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_dv,
  input  logic [CW-1:0] i_data,
  output logic          o_ready,
  input  logic          i_clear,
  output logic          o_wr_en,
  output logic [CW-1:0] o_wr_character,
  output logic [XW-1:0] o_wr_x_pos,
  output logic [YW-1:0] o_wr_y_pos,
  output logic [XW-1:0] o_cursor_x,
  output logic [YW-1:0] o_cursor_y,
  output logic          o_busy
);

  localparam logic [XW-1:0] c_x_last = XW'(COLUMNS - 1);
  localparam logic [YW-1:0] c_y_last = YW'(ROWS - 1);
  localparam logic [CW-1:0] c_blank  = CW'(BLANK_CHAR);
  localparam logic [CW-1:0] c_bs     = CW'(CTRL_BS);
  localparam logic [CW-1:0] c_lf     = CW'(CTRL_LF);
  localparam logic [CW-1:0] c_ff     = CW'(CTRL_FF);
  localparam logic [CW-1:0] c_cr     = CW'(CTRL_CR);

  // Cell that follows (0,0) in the sweep; a triggered clear writes (0,0)
  // in the same edge and continues from here.
  localparam logic [XW-1:0] c_sweep2_x = (COLUMNS > 1) ? XW'(1) : '0;
  localparam logic [YW-1:0] c_sweep2_y = (COLUMNS > 1 || ROWS == 1) ? '0 : YW'(1);
  localparam logic          c_one_cell = (COLUMNS * ROWS == 1);

  state_t          r_state;
  logic [XW-1:0]   r_cursor_x;
  logic [YW-1:0]   r_cursor_y;
  logic            r_sweep_done;
  logic            r_wr_en;
  logic [CW-1:0]   r_wr_character;
  logic [XW-1:0]   r_wr_x_pos;
  logic [YW-1:0]   r_wr_y_pos;

  logic [XW-1:0]   w_adv_x;
  logic [YW-1:0]   w_adv_y;
  logic [YW-1:0]   w_y_inc;
  logic            w_at_last;
  logic            w_accept;
  logic            w_clear_req;

  // Row-major advance by compare-and-wrap; shared by printing and the sweep.
  assign w_y_inc   = (r_cursor_y == c_y_last) ? '0 : r_cursor_y + YW'(1);
  assign w_adv_x   = (r_cursor_x == c_x_last) ? '0 : r_cursor_x + XW'(1);
  assign w_adv_y   = (r_cursor_x == c_x_last) ? w_y_inc : r_cursor_y;
  assign w_at_last = (r_cursor_x == c_x_last) && (r_cursor_y == c_y_last);

  assign o_ready     = (r_state == IDLE) && !i_clear;
  assign w_accept    = i_dv && o_ready;
  // Only meaningful in IDLE; a clear request during CLEAR is ignored.
  assign w_clear_req = i_clear || (w_accept && (i_data == c_ff));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= CLEAR;
      r_cursor_x     <= '0;
      r_cursor_y     <= '0;
      r_sweep_done   <= 1'b0;
      r_wr_en        <= 1'b0;
      r_wr_character <= '0;
      r_wr_x_pos     <= '0;
      r_wr_y_pos     <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        CLEAR: begin
          // The cursor doubles as the sweep counter; after the last cell it
          // has wrapped back to (0,0), which is the required home position.
          if (r_sweep_done) begin
            r_state      <= IDLE;
            r_sweep_done <= 1'b0;
          end else begin
            r_wr_en        <= 1'b1;
            r_wr_character <= c_blank;
            r_wr_x_pos     <= r_cursor_x;
            r_wr_y_pos     <= r_cursor_y;
            r_cursor_x     <= w_adv_x;
            r_cursor_y     <= w_adv_y;
            r_sweep_done   <= w_at_last;
          end
        end
        IDLE: begin
          if (w_clear_req) begin
            // First sweep write happens on the triggering edge so the
            // writes line up with the cycles right after the request.
            r_state        <= CLEAR;
            r_wr_en        <= 1'b1;
            r_wr_character <= c_blank;
            r_wr_x_pos     <= '0;
            r_wr_y_pos     <= '0;
            r_cursor_x     <= c_sweep2_x;
            r_cursor_y     <= c_sweep2_y;
            r_sweep_done   <= c_one_cell;
          end else if (w_accept) begin
            if (i_data == c_cr) begin
              r_cursor_x <= '0;
            end else if (i_data == c_lf) begin
              r_cursor_x <= '0;
              r_cursor_y <= w_y_inc;
            end else if (i_data == c_bs) begin
              if (r_cursor_x != '0) begin
                r_cursor_x     <= r_cursor_x - XW'(1);
                r_wr_en        <= 1'b1;
                r_wr_character <= c_blank;
                r_wr_x_pos     <= r_cursor_x - XW'(1);
                r_wr_y_pos     <= r_cursor_y;
              end else if (r_cursor_y != '0) begin
                r_cursor_x     <= c_x_last;
                r_cursor_y     <= r_cursor_y - YW'(1);
                r_wr_en        <= 1'b1;
                r_wr_character <= c_blank;
                r_wr_x_pos     <= c_x_last;
                r_wr_y_pos     <= r_cursor_y - YW'(1);
              end
            end else begin
              // Printable: write at the pre-advance cursor
              r_wr_en        <= 1'b1;
              r_wr_character <= i_data;
              r_wr_x_pos     <= r_cursor_x;
              r_wr_y_pos     <= r_cursor_y;
              r_cursor_x     <= w_adv_x;
              r_cursor_y     <= w_adv_y;
            end
          end
        end
        default: begin
          r_state <= CLEAR;
        end
      endcase
    end
  end

  assign o_wr_en        = r_wr_en;
  assign o_wr_character = r_wr_character;
  assign o_wr_x_pos     = r_wr_x_pos;
  assign o_wr_y_pos     = r_wr_y_pos;
  assign o_cursor_x     = r_cursor_x;
  assign o_cursor_y     = r_cursor_y;
  assign o_busy         = (r_state == CLEAR);

endmodule : text_console_writer
`default_nettype wire

// File: tb/tb_text_console_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_console_writer
//  Description : Directed self-checking bench for text_console_writer
//                (12 columns x 2 rows).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_text_console_writer;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_dv;
  logic [7:0] i_data;
  logic       o_ready;
  logic       i_clear;
  logic       o_wr_en;
  logic [7:0] o_wr_character;
  logic [3:0] o_wr_x_pos;
  logic [0:0] o_wr_y_pos;
  logic [3:0] o_cursor_x;
  logic [0:0] o_cursor_y;
  logic       o_busy;

  int errors = 0;
  int checks = 0;

  text_console_writer #(
    .COLUMNS      (12),
    .ROWS         (2),
    .FONT_NUM_CHAR(256),
    .BLANK_CHAR   (8'h20)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_dv          (i_dv),
    .i_data        (i_data),
    .o_ready       (o_ready),
    .i_clear       (i_clear),
    .o_wr_en       (o_wr_en),
    .o_wr_character(o_wr_character),
    .o_wr_x_pos    (o_wr_x_pos),
    .o_wr_y_pos    (o_wr_y_pos),
    .o_cursor_x    (o_cursor_x),
    .o_cursor_y    (o_cursor_y),
    .o_busy        (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Drive one code for one rising edge; returns at the following falling
  // edge, where that edge's registered results are visible.
  task automatic send_code(input logic [7:0] c);
    i_dv   = 1'b1;
    i_data = c;
    @(posedge i_clk);
    @(negedge i_clk);
    i_dv   = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b1; i_dv = 1'b0; i_data = 8'h00; i_clear = 1'b0;
    #2 i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++; if (o_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", o_wr_en); end
    checks++; if (o_wr_character !== 8'h00) begin errors++; $display("FAIL reset_wr_char: got %h want 00", o_wr_character); end
    checks++; if ({o_wr_x_pos, o_wr_y_pos, o_cursor_x, o_cursor_y} !== 10'd0) begin errors++; $display("FAIL reset_pos: wr=(%0d,%0d) cur=(%0d,%0d) want all 0", o_wr_x_pos, o_wr_y_pos, o_cursor_x, o_cursor_y); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", o_ready); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", o_busy); end
    i_rst_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge i_clk);
      checks++;
      if (o_wr_en !== 1'b1 || o_wr_character !== 8'h20 || o_wr_x_pos !== 4'(k % 12) ||
          o_wr_y_pos !== 1'(k / 12) || o_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_sweep[%0d]: en=%b ch=%h pos=(%0d,%0d) rdy=%b want en=1 ch=20 pos=(%0d,%0d) rdy=0",
                 k, o_wr_en, o_wr_character, o_wr_x_pos, o_wr_y_pos, o_ready, k % 12, k / 12);
      end
    end
    @(negedge i_clk);
    checks++;
    if (o_wr_en !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_cursor_x !== 4'd0 || o_cursor_y !== 1'd0) begin
      errors++;
      $display("FAIL reset_done: en=%b rdy=%b busy=%b cur=(%0d,%0d) want en=0 rdy=1 busy=0 cur=(0,0)",
               o_wr_en, o_ready, o_busy, o_cursor_x, o_cursor_y);
    end
  endtask

  task automatic test_single();
    send_code(8'h41);
    checks++;
    if (o_wr_en !== 1'b1 || o_wr_character !== 8'h41 || o_wr_x_pos !== 4'd0 || o_wr_y_pos !== 1'd0) begin
      errors++;
      $display("FAIL single_write: en=%b ch=%h pos=(%0d,%0d) want en=1 ch=41 pos=(0,0)",
               o_wr_en, o_wr_character, o_wr_x_pos, o_wr_y_pos);
    end
    checks++; if (o_cursor_x !== 4'd1 || o_cursor_y !== 1'd0) begin errors++; $display("FAIL single_cursor: got (%0d,%0d) want (1,0)", o_cursor_x, o_cursor_y); end
    @(negedge i_clk);
    checks++; if (o_wr_en !== 1'b0) begin errors++; $display("FAIL single_pulse: wr_en got %b want 0", o_wr_en); end
  endtask

  task automatic test_back_to_back();
    send_code(8'h0D);
    checks++; if (o_wr_en !== 1'b0 || o_cursor_x !== 4'd0 || o_cursor_y !== 1'd0) begin errors++; $display("FAIL b2b_home: en=%b cur=(%0d,%0d) want en=0 cur=(0,0)", o_wr_en, o_cursor_x, o_cursor_y); end
    for (int k = 0; k <= 25; k++) begin
      if (k > 0) begin
        checks++;
        if (o_wr_en !== 1'b1 || o_wr_character !== 8'(8'h30 + k - 1) ||
            o_wr_x_pos !== 4'((k - 1) % 12) || o_wr_y_pos !== 1'(((k - 1) / 12) % 2)) begin
          errors++;
          $display("FAIL b2b_write[%0d]: en=%b ch=%h pos=(%0d,%0d) want en=1 ch=%h pos=(%0d,%0d)",
                   k - 1, o_wr_en, o_wr_character, o_wr_x_pos, o_wr_y_pos,
                   8'(8'h30 + k - 1), (k - 1) % 12, ((k - 1) / 12) % 2);
        end
      end
      if (k < 25) begin
        i_dv = 1'b1; i_data = 8'(8'h30 + k);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, o_ready); end
      end else begin
        i_dv = 1'b0;
      end
      @(posedge i_clk);
      @(negedge i_clk);
    end
    checks++; if (o_wr_en !== 1'b0 || o_cursor_x !== 4'd1 || o_cursor_y !== 1'd0) begin errors++; $display("FAIL b2b_end: en=%b cur=(%0d,%0d) want en=0 cur=(1,0)", o_wr_en, o_cursor_x, o_cursor_y); end
  endtask

  task automatic test_backspace();
    // cursor (1,0) -> 11 printables -> (0,1)
    for (int k = 0; k < 11; k++) send_code(8'h61);
    checks++; if (o_cursor_x !== 4'd0 || o_cursor_y !== 1'd1) begin errors++; $display("FAIL bs_setup: cur=(%0d,%0d) want (0,1)", o_cursor_x, o_cursor_y); end
    send_code(8'h08);
    checks++;
    if (o_wr_en !== 1'b1 || o_wr_character !== 8'h20 || o_wr_x_pos !== 4'd11 || o_wr_y_pos !== 1'd0 ||
        o_cursor_x !== 4'd11 || o_cursor_y !== 1'd0) begin
      errors++;
      $display("FAIL bs_rowup: en=%b ch=%h pos=(%0d,%0d) cur=(%0d,%0d) want en=1 ch=20 pos=(11,0) cur=(11,0)",
               o_wr_en, o_wr_character, o_wr_x_pos, o_wr_y_pos, o_cursor_x, o_cursor_y);
    end
    send_code(8'h0D);
    send_code(8'h08);
    checks++; if (o_wr_en !== 1'b0 || o_cursor_x !== 4'd0 || o_cursor_y !== 1'd0) begin errors++; $display("FAIL bs_origin: en=%b cur=(%0d,%0d) want en=0 cur=(0,0)", o_wr_en, o_cursor_x, o_cursor_y); end
    send_code(8'h41);
    send_code(8'h08);
    checks++;
    if (o_wr_en !== 1'b1 || o_wr_character !== 8'h20 || o_wr_x_pos !== 4'd0 || o_wr_y_pos !== 1'd0 ||
        o_cursor_x !== 4'd0 || o_cursor_y !== 1'd0) begin
      errors++;
      $display("FAIL bs_inline: en=%b ch=%h pos=(%0d,%0d) cur=(%0d,%0d) want en=1 ch=20 pos=(0,0) cur=(0,0)",
               o_wr_en, o_wr_character, o_wr_x_pos, o_wr_y_pos, o_cursor_x, o_cursor_y);
    end
  endtask

  task automatic test_crlf();
    send_code(8'h0A);
    checks++; if (o_wr_en !== 1'b0 || o_cursor_x !== 4'd0 || o_cursor_y !== 1'd1) begin errors++; $display("FAIL lf_down: en=%b cur=(%0d,%0d) want en=0 cur=(0,1)", o_wr_en, o_cursor_x, o_cursor_y); end
    for (int k = 0; k < 5; k++) send_code(8'h62);
    checks++; if (o_cursor_x !== 4'd5 || o_cursor_y !== 1'd1) begin errors++; $display("FAIL lf_setup: cur=(%0d,%0d) want (5,1)", o_cursor_x, o_cursor_y); end
    send_code(8'h0A);
    checks++; if (o_wr_en !== 1'b0 || o_cursor_x !== 4'd0 || o_cursor_y !== 1'd0) begin errors++; $display("FAIL lf_wrap: en=%b cur=(%0d,%0d) want en=0 cur=(0,0)", o_wr_en, o_cursor_x, o_cursor_y); end
    for (int k = 0; k < 5; k++) send_code(8'h63);
    send_code(8'h0D);
    checks++; if (o_wr_en !== 1'b0 || o_cursor_x !== 4'd0 || o_cursor_y !== 1'd0) begin errors++; $display("FAIL cr_home: en=%b cur=(%0d,%0d) want en=0 cur=(0,0)", o_wr_en, o_cursor_x, o_cursor_y); end
  endtask

  // v=0: i_clear with a coincident byte; v=1: FF code; v=2: extra i_clear mid-sweep
  task automatic test_clear();
    for (int v = 0; v < 3; v++) begin
      send_code(8'h5A);
      if (v == 1) begin
        i_dv = 1'b1; i_data = 8'h0C;
      end else begin
        i_clear = 1'b1; i_dv = (v == 0); i_data = 8'h42;
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL clear_ready_comb[%0d]: got %b want 0", v, o_ready); end
      end
      @(posedge i_clk);
      @(negedge i_clk);
      i_clear = 1'b0; i_dv = 1'b0;
      for (int k = 0; k < 24; k++) begin
        if (v == 2 && k == 10) i_clear = 1'b1;
        if (v == 2 && k == 11) i_clear = 1'b0;
        checks++;
        if (o_wr_en !== 1'b1 || o_wr_character !== 8'h20 || o_wr_x_pos !== 4'(k % 12) ||
            o_wr_y_pos !== 1'(k / 12) || o_ready !== 1'b0 || o_busy !== 1'b1) begin
          errors++;
          $display("FAIL clear_sweep[%0d][%0d]: en=%b ch=%h pos=(%0d,%0d) rdy=%b busy=%b want en=1 ch=20 pos=(%0d,%0d) rdy=0 busy=1",
                   v, k, o_wr_en, o_wr_character, o_wr_x_pos, o_wr_y_pos, o_ready, o_busy, k % 12, k / 12);
        end
        @(negedge i_clk);
      end
      checks++;
      if (o_wr_en !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_cursor_x !== 4'd0 || o_cursor_y !== 1'd0) begin
        errors++;
        $display("FAIL clear_done[%0d]: en=%b rdy=%b busy=%b cur=(%0d,%0d) want en=0 rdy=1 busy=0 cur=(0,0)",
                 v, o_wr_en, o_ready, o_busy, o_cursor_x, o_cursor_y);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int pulses;
    send_code(8'h0C);
    repeat (5) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_wr_en !== 1'b0 || o_busy !== 1'b1 || o_ready !== 1'b0 || o_cursor_x !== 4'd0 || o_wr_x_pos !== 4'd0) begin
      errors++;
      $display("FAIL midreset_async: en=%b busy=%b rdy=%b cur_x=%0d wr_x=%0d want en=0 busy=1 rdy=0 cur_x=0 wr_x=0",
               o_wr_en, o_busy, o_ready, o_cursor_x, o_wr_x_pos);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge i_clk);
      if (o_wr_en === 1'b1 && o_wr_character === 8'h20) pulses++;
    end
    checks++; if (pulses !== 24) begin errors++; $display("FAIL midreset_sweep_len: got %0d writes want 24", pulses); end
    checks++; if (o_ready !== 1'b1 || o_cursor_x !== 4'd0 || o_cursor_y !== 1'd0) begin errors++; $display("FAIL midreset_done: rdy=%b cur=(%0d,%0d) want rdy=1 cur=(0,0)", o_ready, o_cursor_x, o_cursor_y); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backspace();
    test_crlf();
    test_clear();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_text_console_writer
`default_nettype wire

// File: doc/text_console_writer.md
# text_console_writer

Character-stream front end for the text overlay: accepts a byte-wide stream of character codes (e.g. from a UART receiver) and drives the overlay's character-table write port. Each write carries a code, column and row. Maintains a cursor with row-major advance, wrap-around and basic control codes. Blanks the whole table after reset and on request. Sits between the stream source and the overlay's write port, in the same `i_clk` domain.

## Interface
- `COLUMNS`, 12, text columns; must match the overlay.
- `ROWS`, 2, text rows; must match the overlay.
- `FONT_NUM_CHAR`, 256, glyph count; code width is CW = $clog2(FONT_NUM_CHAR).
- `BLANK_CHAR`, 8'h20, code written by clear and backspace.
- XW = max(1,$clog2(COLUMNS)), YW = max(1,$clog2(ROWS)).

- `i_clk`  in  1  single clock; all logic on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_dv`  in  1  input code valid.
- `i_data`  in  CW  input character/control code.
- `o_ready`  out  1  block can accept a code this cycle.
- `i_clear`  in  1  single-cycle clear-screen request.
- `o_wr_en`  out  1  character-table write strobe.
- `o_wr_character`  out  CW  code to write.
- `o_wr_x_pos`  out  XW  write column.
- `o_wr_y_pos`  out  YW  write row.
- `o_cursor_x`  out  XW  current cursor column.
- `o_cursor_y`  out  YW  current cursor row.
- `o_busy`  out  1  clear sweep in progress.

## Operation
- FSM states: CLEAR, IDLE. Reset enters CLEAR with sweep counter at (0,0).
- `o_ready` = (state==IDLE) && !`i_clear`, combinational. A code is accepted when `i_dv && o_ready`.
- IDLE, printable code (any code other than those below):
  - write the code at the cursor;
  - advance x; at x==COLUMNS-1, wrap to x=0, y+1;
  - at (COLUMNS-1, ROWS-1), wrap to (0,0). No scrolling.
- 0x0D (CR): x=0; no write.
- 0x0A (LF): x=0, y+1, wrapping to 0 after ROWS-1; no write.
- 0x08 (BS):
  - if x>0: x-1, write BLANK_CHAR at the new position;
  - if x==0 and y>0: move to (COLUMNS-1, y-1) and write BLANK_CHAR there;
  - at (0,0): no move, no write.
- 0x0C (FF): same as `i_clear`.
- Clear trigger:
  - `i_clear` in IDLE goes to CLEAR.
  - `i_clear` coinciding with `i_dv` drops the byte, because `o_ready` is low.
  - `i_clear` while in CLEAR is ignored; the sweep is not restarted.
- CLEAR sweep:
  - writes BLANK_CHAR to every cell, one per cycle, row-major from (0,0) to (COLUMNS-1, ROWS-1);
  - takes COLUMNS*ROWS cycles;
  - then sets the cursor to (0,0) and returns to IDLE;
  - `o_busy`=1 throughout.
- Throughput: one accepted code per cycle in IDLE. Back-to-back codes need no stall.

## Timing
- Reset values: all outputs 0 (`o_wr_en`=0, `o_wr_character`=0, positions 0, cursor (0,0)), `o_ready`=0. `o_busy`=1, since the state is CLEAR.
- First sweep write is registered on the first rising edge after `i_rst_n` deasserts.
- `o_wr_*` outputs are registered. A code accepted at edge N produces `o_wr_en`=1 during cycle N+1.
- The write address is the pre-advance cursor for printable codes, and the post-move position for BS.
- Cursor outputs show the updated value in cycle N+1.
- `o_wr_en` is a single-cycle pulse per write. It is 0 for CR, LF and no-op BS.
- Clear: `i_clear` sampled at edge N gives `o_ready`=0 from cycle N+1. Writes occupy cycles N+1 through N+COLUMNS*ROWS. IDLE with `o_ready`=1 and cursor (0,0) follows in cycle N+COLUMNS*ROWS+1.
- Reset asserted mid-sweep or mid-write: outputs go to reset values immediately, and a full sweep runs after release.
- Cursor arithmetic uses explicit compare-and-wrap, never modulo on non-power-of-2 bounds. x and y never exceed COLUMNS-1 and ROWS-1.

## Structure
- Shared package `text_pkg`:
  - control-code constants CTRL_BS, CTRL_LF, CTRL_FF, CTRL_CR;
  - FSM state enum {CLEAR, IDLE}.
- Single module, no sub-module. The clear sweep reuses the cursor counters and their wrap logic.

## Test plan
- Reset release (COLUMNS=12, ROWS=2):
  - 24 consecutive `o_wr_en` pulses with code 0x20 at (0,0),(1,0)…(11,1);
  - `o_ready`=0 throughout, then 1 with cursor (0,0).
- Send 0x41 at (0,0) -> next cycle `o_wr_en`=1, code 0x41, pos (0,0); cursor (1,0).
- Send 25 printable codes back-to-back:
  - 12th written at (11,0), 13th at (0,1), 24th at (11,1), 25th at (0,0);
  - `o_ready` stays 1.
- Backspace:
  - cursor (0,1), send 0x08 -> write 0x20 at (11,0), cursor (11,0);
  - cursor (0,0), send 0x08 -> no write, cursor (0,0).
- CR/LF:
  - cursor (5,1), send 0x0A -> cursor (0,0), no write;
  - cursor (5,0), send 0x0D -> cursor (0,0), no write.
- Clear requests:
  - `i_clear` together with `i_dv`=1, data 0x42 -> 0x42 never written; 24-cycle sweep; cursor (0,0);
  - sending 0x0C behaves identically;
  - `i_clear` pulsed mid-sweep -> sweep length unchanged.
